// File: rtl/unidade_mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the default operand width.
package unidade_mult_div_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } md_state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/unidade_mult_div_if.sv
// Request/response bundle between the register bank / control FSM and the
// multiply/divide unit.
interface unidade_mult_div_if #(
  parameter int unsigned N = unidade_mult_div_pkg::MD_WIDTH
);
  logic         md_in_start;
  logic [1:0]   md_in_op;
  logic [N-1:0] md_in_R_rs;
  logic [N-1:0] md_in_R_rt;
  logic         md_in_sel_hi;
  logic         md_out_busy;
  logic         md_out_done;
  logic         md_out_div_zero;
  logic [N-1:0] md_out_data;
  logic [N-1:0] md_out_hi;
  logic [N-1:0] md_out_lo;

  modport master (
    output md_in_start, md_in_op, md_in_R_rs, md_in_R_rt, md_in_sel_hi,
    input  md_out_busy, md_out_done, md_out_div_zero, md_out_data, md_out_hi, md_out_lo
  );

  modport slave (
    input  md_in_start, md_in_op, md_in_R_rs, md_in_R_rt, md_in_sel_hi,
    output md_out_busy, md_out_done, md_out_div_zero, md_out_data, md_out_hi, md_out_lo
  );
endinterface

// File: rtl/md_iterador.sv
// Single combinational iteration: shift-add multiply step, plus a restoring
// shift-subtract divide step when MD_DIV_EN is defined.
module md_iterador
  import unidade_mult_div_pkg::*;
#(
  parameter int unsigned N = MD_WIDTH
) (
  input  logic [N-1:0]   opnd,
  input  logic [2*N-1:0] acc,
  output logic [2*N-1:0] acc_next
`ifdef MD_DIV_EN
  ,
  input  logic           is_div,
  input  logic [N:0]     rem,
  output logic [N:0]     rem_next
`endif
);

  logic [N-1:0] addend;
  logic [N:0]   sum;
`ifdef MD_DIV_EN
  logic [N+1:0] diff;
  logic         ge;
`endif

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}
    addend   = acc[0] ? opnd : '0;
    sum      = {1'b0, acc[2*N-1:N]} + {1'b0, addend};
    acc_next = {sum, acc[N-1:1]};
`ifdef MD_DIV_EN
    // Divide: dividend bits leave acc[N-1] and quotient bits enter at acc[0]
    diff     = {rem, acc[N-1]} - {2'b00, opnd};
    ge       = ~diff[N+1];
    rem_next = rem;
    if (is_div) begin
      rem_next = ge ? diff[N:0] : {rem[N-1:0], acc[N-1]};
      acc_next = {acc[2*N-1:N], acc[N-2:0], ge};
    end
`endif
  end

endmodule

// File: rtl/unidade_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers (N+2 cycle latency).
// Divider support is compiled in only when MD_DIV_EN is defined.
module unidade_mult_div
  import unidade_mult_div_pkg::*;
#(
  parameter int unsigned N = MD_WIDTH
) (
  input  logic                md_in_clk,
  input  logic                md_in_rst_n,
  unidade_mult_div_if.slave   md
);

  localparam int unsigned CW = $clog2(N);

  md_state_t      state, state_next;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   opnd, hi_q, lo_q, hi_w, lo_w, mag_rs, mag_rt;
  logic [2*N-1:0] acc, acc_next, prod;
  logic           neg_a, neg_b, accept, req_div, req_signed;
`ifdef MD_DIV_EN
  logic [N:0]     rem, rem_next;
  logic           is_div_q, dz_q;
`endif

  assign req_div    = op_is_div(md.md_in_op);
  assign req_signed = op_is_signed(md.md_in_op);
  assign accept     = md.md_in_start && ((state == IDLE) || (state == DONE));
  assign mag_rs     = (req_signed && md.md_in_R_rs[N-1]) ? -md.md_in_R_rs : md.md_in_R_rs;
  assign mag_rt     = (req_signed && md.md_in_R_rt[N-1]) ? -md.md_in_R_rt : md.md_in_R_rt;

  md_iterador #(.N(N)) u_iter (
    .opnd     (opnd),
    .acc      (acc),
    .acc_next (acc_next)
`ifdef MD_DIV_EN
    ,
    .is_div   (is_div_q),
    .rem      (rem),
    .rem_next (rem_next)
`endif
  );

  always_ff @(posedge md_in_clk or negedge md_in_rst_n) begin
    if (!md_in_rst_n) state <= IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (accept) begin
`ifdef MD_DIV_EN
          state_next = RUN;
`else
          state_next = req_div ? DONE : RUN;
`endif
        end
      end
      RUN:     if (cnt == CW'(N-1)) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Sign correction applied on the way into HI/LO
  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc : acc;
    hi_w = prod[2*N-1:N];
    lo_w = prod[N-1:0];
`ifdef MD_DIV_EN
    if (is_div_q) begin
      lo_w = dz_q ? '1 : ((neg_a ^ neg_b) ? -acc[N-1:0] : acc[N-1:0]);
      hi_w = neg_a ? -rem[N-1:0] : rem[N-1:0];
    end
`endif
  end

  always_ff @(posedge md_in_clk or negedge md_in_rst_n) begin
    if (!md_in_rst_n) begin
      cnt   <= '0;
      opnd  <= '0;
      acc   <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
`ifdef MD_DIV_EN
      rem      <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else if (accept) begin
      cnt   <= '0;
      neg_a <= req_signed && md.md_in_R_rs[N-1];
      neg_b <= req_signed && md.md_in_R_rt[N-1];
`ifdef MD_DIV_EN
      rem      <= '0;
      is_div_q <= req_div;
      dz_q     <= req_div && (md.md_in_R_rt == '0);
      opnd     <= req_div ? mag_rt : mag_rs;
      acc      <= {{N{1'b0}}, (req_div ? mag_rs : mag_rt)};
`else
      opnd     <= mag_rs;
      acc      <= {{N{1'b0}}, mag_rt};
`endif
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      acc <= acc_next;
`ifdef MD_DIV_EN
      rem <= rem_next;
`endif
    end else if (state == FIX) begin
      hi_q <= hi_w;
      lo_q <= lo_w;
    end
  end

  assign md.md_out_busy = (state == RUN) || (state == FIX);
  assign md.md_out_done = (state == DONE);
`ifdef MD_DIV_EN
  assign md.md_out_div_zero = (state == DONE) && dz_q;
`else
  assign md.md_out_div_zero = 1'b0;
`endif
  assign md.md_out_data = md.md_in_sel_hi ? hi_q : lo_q;
  assign md.md_out_hi   = hi_q;
  assign md.md_out_lo   = lo_q;

endmodule

// File: doc/unidade_mult_div.md
# unidade_mult_div

Iterative multiply/divide unit with architectural HI/LO registers for the multicycle MIPS core. Sits directly downstream of the register bank:
- consumes the rs/rt read values for MULT, MULTU, DIV and DIVU;
- returns HI or LO through its data output, which the control FSM routes to the register bank write-data input for MFHI/MFLO.

## Interface
- N, 32, operand width in bits; HI and LO are each N bits.
- md_in_clk  in  1  clock; all state changes on the rising edge.
- md_in_rst_n  in  1  reset, asynchronous, active-low.
- md_in_start  in  1  request pulse; sampled only when the unit is not busy.
- md_in_op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- md_in_R_rs  in  N  first operand (multiplicand or dividend), from the register bank rs port.
- md_in_R_rt  in  N  second operand (multiplier or divisor), from the register bank rt port.
- md_in_sel_hi  in  1  1 selects HI, 0 selects LO, on md_out_data.
- md_out_busy  out  1  high in states RUN and FIX.
- md_out_done  out  1  high for exactly the one DONE cycle.
- md_out_div_zero  out  1  high during DONE when the finished operation was DIV or DIVU with a zero divisor.
- md_out_data  out  N  combinational mux: HI when md_in_sel_hi is 1, otherwise LO.
- md_out_hi, md_out_lo  out  N each  direct views of the HI and LO registers.

## Operation
The control state machine has four states:
- IDLE
  - On md_in_start: latch the op and operand magnitudes (absolute values for signed ops), record the sign flags, clear the counter, go to RUN.
- RUN
  - Performs one iteration per cycle.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - After N iterations, go to FIX.
- FIX
  - Applies sign correction and writes HI/LO, then goes to DONE.
  - MULT: the 2N-bit product is negated if the operand signs differ; HI gets the upper half, LO the lower half.
  - DIV: the quotient goes to LO and is negated if the signs differ; the remainder goes to HI and takes the sign of the dividend.
  - Unsigned ops: no correction.
- DONE
  - Asserts md_out_done.
  - Next state is IDLE, or RUN if md_in_start is high. A start in DONE is accepted exactly as in IDLE.

Arithmetic and boundary behaviour:
- Accumulator is 2N bits; the divider's partial remainder is N+1 bits.
- Divide by zero runs the full latency. Result: LO = all ones, HI = md_in_R_rs unchanged, md_out_div_zero = 1.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0; the magnitude result is truncated and no flag is raised.
- md_in_start while busy is ignored. Operands and op are not re-sampled, and the in-flight result is unaffected.
- HI/LO hold their value between operations and change only in FIX.

## Timing
- All outputs reset to 0: busy, done, div_zero, HI, LO, and therefore data, hi and lo.
- Reset asserted mid-operation aborts immediately: state goes to IDLE, HI/LO are cleared, and no done is produced.
- Start sampled at the end of cycle 0 leads to:
  - RUN in cycles 1..N;
  - FIX in cycle N+1, with HI/LO written at its closing edge;
  - DONE in cycle N+2 (cycle 34 for N=32), with HI/LO already valid.
- The control FSM may issue MFHI/MFLO from the DONE cycle onward.
- Back-to-back operations: start during DONE gives a throughput of one operation per N+2 cycles.

## Configuration
Macro: MD_DIV_EN.
- Defined: DIV and DIVU are implemented as described.
- Undefined:
  - The divider datapath is omitted.
  - DIV/DIVU starts go straight from IDLE to DONE in the next cycle.
  - HI/LO stay unchanged and md_out_div_zero stays 0.
  - Multiplies are unaffected.

## Structure
- Shared package unidade_mult_div_pkg holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, RUN, FIX, DONE);
  - the default width constant.
- One sub-module, md_iterador: purely combinational single-iteration step.
  - Shift-add for multiply.
  - Shift-subtract with restore for divide.
  - Instantiated once by unidade_mult_div, which owns the FSM, counter, sign flags and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done high only in cycle 34; busy high in cycles 1..33.
- MULT 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; with sel_hi=0, data=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x64 ÷ 0 → LO=0xFFFFFFFF, HI=0x64, div_zero=1 for one cycle.
- Start MULTU 3×4, then assert start with 7×7 in cycle 5 → ignored, LO=12. Then start in the DONE cycle → second op's done in cycle 68.
- Drop md_in_rst_n in cycle 10 of a running MULT → busy=0 and HI=LO=0 immediately; no done follows.
